writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles spent in WAIT_MEM for a load response (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (MEM stage) has an instruction to retire.
REQ-005 in_ready  output  1  unit accepts the instruction this cycle.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_regwrite  input  1  instruction writes a register.
REQ-008 in_is_load  input  1  instruction is a load; in_result carries the byte address.
REQ-009 in_funct3  input  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 in_result  input  32  ALU result (non-load) or effective address (load).
REQ-011 mem_rvalid  input  1  data-memory read response valid.
REQ-012 mem_rdata  input  32  data-memory read word (word-aligned, little-endian).
REQ-013 RegWrite  output  1  register-file write enable.
REQ-014 WriteAddr  output  5  register-file write index.
REQ-015 WriteData  output  32  register-file write data.
REQ-016 err  output  1  one-cycle pulse: misaligned/illegal load or timeout.

Function
REQ-017 FSM states SHALL be IDLE, WAIT_MEM, WB; accept = in_valid && in_ready.
REQ-018 in_ready SHALL be 1 in IDLE and WB, 0 in WAIT_MEM.
REQ-019 Accept of non-load SHALL go to WB next cycle, latching in_rd and in_result; latency 1 cycle.
REQ-020 Accept of load SHALL go to WAIT_MEM, latching rd, regwrite, funct3, address[1:0]; timeout counter cleared.
REQ-021 In WAIT_MEM, mem_rvalid=1 SHALL capture aligned/extended mem_rdata and go to WB next cycle.
REQ-022 Alignment: LB/LBU select byte addr[1:0]; LH/LHU select halfword addr[1]; LW whole word; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-023 Load with LH/LHU and addr[0]=1, LW and addr[1:0]!=0, or funct3 not in REQ-009 list SHALL be rejected at accept: no WAIT_MEM, no write, err=1 next cycle, state IDLE.
REQ-024 In WB, RegWrite SHALL be 1 for exactly that cycle iff latched regwrite=1 and latched rd!=0; WriteAddr/WriteData hold latched values.
REQ-025 Outside WB, RegWrite SHALL be 0; WriteAddr/WriteData hold last values.
REQ-026 WB with accept SHALL transition per REQ-019/020 (back-to-back non-loads sustain 1 write/cycle); WB without accept SHALL return to IDLE.
REQ-027 Counter SHALL increment each WAIT_MEM cycle without mem_rvalid; reaching TIMEOUT SHALL pulse err, discard the load, return to IDLE, no write.
REQ-028 mem_rvalid on the same cycle the counter reaches TIMEOUT SHALL win: data written, no err.
REQ-029 mem_rvalid in IDLE or WB SHALL be ignored.
REQ-030 in_rd=0 or in_regwrite=0 SHALL still traverse states normally, with RegWrite held 0.

Reset
REQ-031 reset=1 at a clock edge SHALL set state IDLE, RegWrite 0, WriteAddr 0, WriteData 0, err 0, counter 0.
REQ-032 reset SHALL take priority over every other input, including during WAIT_MEM (pending load abandoned, no write).
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-034 Non-load rd=5, result=0x12345678 accepted cycle N -> RegWrite=1, WriteAddr=5, WriteData=0x12345678 in cycle N+1 only.
REQ-035 LB addr=0x1003, mem_rdata=0x80FF_0000 after 3 wait cycles, rd=7 -> in_ready=0 during wait; RegWrite=1, WriteData=0xFFFFFF80 cycle after rvalid.
REQ-036 LHU addr=0x2002, mem_rdata=0xBEEF1234, rd=9 -> WriteData=0x0000BEEF; LH addr=0x2001 -> err pulse, no RegWrite.
REQ-037 Load with no mem_rvalid (TIMEOUT=15) -> err=1 after 15 WAIT_MEM cycles, RegWrite never asserted, in_ready=1 next cycle; repeat with rvalid on cycle 15 -> write, no err.
REQ-038 Four back-to-back non-loads rd=1..4 -> four consecutive RegWrite pulses; rd=0 instance -> RegWrite=0 that cycle.
REQ-039 reset asserted during WAIT_MEM, then mem_rvalid -> no RegWrite, all outputs 0, state IDLE.

Source files
------------

// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - retire handshake, load response and register-file write bundle
interface writeback_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        RegWrite;
  logic [4:0]  WriteAddr;
  logic [31:0] WriteData;
  logic        err;

  // Upstream/memory side: drives the instruction and the load response.
  modport master (
    output in_valid, in_rd, in_regwrite, in_is_load, in_funct3, in_result,
    output mem_rvalid, mem_rdata,
    input  in_ready, RegWrite, WriteAddr, WriteData, err
  );

  // Writeback unit side.
  modport slave (
    input  in_valid, in_rd, in_regwrite, in_is_load, in_funct3, in_result,
    input  mem_rvalid, mem_rdata,
    output in_ready, RegWrite, WriteAddr, WriteData, err
  );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - retires ALU results and loads into the register file
module writeback_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  writeback_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_MEM, WB} state_t;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  state_t      state, stateNext;
  logic [7:0]  waitCnt;
  logic [4:0]  ldRd;
  logic        ldRegwrite;
  logic [2:0]  ldFunct3;
  logic [1:0]  ldAddr;

  logic        regWriteQ;
  logic [4:0]  writeAddrQ;
  logic [31:0] writeDataQ;
  logic        errQ;

  logic        accept;
  logic        loadLegal;
  logic        takeNonLoad, takeLoad, rejectLoad, loadDone, timeout;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;
  logic [31:0] loadData;

  assign bus.in_ready  = (state != WAIT_MEM);
  assign bus.RegWrite  = regWriteQ;
  assign bus.WriteAddr = writeAddrQ;
  assign bus.WriteData = writeDataQ;
  assign bus.err       = errQ;

  assign accept = bus.in_valid && bus.in_ready;

  // Alignment/width legality of an incoming load, judged at accept time.
  always_comb begin
    loadLegal = 1'b0;
    case (bus.in_funct3)
      F_LB, F_LBU: loadLegal = 1'b1;
      F_LH, F_LHU: loadLegal = !bus.in_result[0];
      F_LW:        loadLegal = (bus.in_result[1:0] == 2'b00);
      default:     loadLegal = 1'b0;
    endcase
  end

  // Select the addressed byte/halfword of the response word and extend it.
  always_comb begin
    loadByte = 8'h00;
    case (ldAddr)
      2'd0: loadByte = bus.mem_rdata[7:0];
      2'd1: loadByte = bus.mem_rdata[15:8];
      2'd2: loadByte = bus.mem_rdata[23:16];
      default: loadByte = bus.mem_rdata[31:24];
    endcase
    loadHalf = ldAddr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (ldFunct3)
      F_LB:    loadData = {{24{loadByte[7]}}, loadByte};
      F_LH:    loadData = {{16{loadHalf[15]}}, loadHalf};
      F_LBU:   loadData = {24'h0, loadByte};
      F_LHU:   loadData = {16'h0, loadHalf};
      default: loadData = bus.mem_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic and the per-cycle events that steer the datapath.
  always_comb begin
    stateNext   = state;
    takeNonLoad = 1'b0;
    takeLoad    = 1'b0;
    rejectLoad  = 1'b0;
    loadDone    = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE, WB: begin
        if (accept) begin
          if (!bus.in_is_load) begin
            takeNonLoad = 1'b1;
            stateNext   = WB;
          end else if (loadLegal) begin
            takeLoad  = 1'b1;
            stateNext = WAIT_MEM;
          end else begin
            rejectLoad = 1'b1;
            stateNext  = IDLE;
          end
        end else begin
          stateNext = IDLE;
        end
      end
      WAIT_MEM: begin
        // A response arriving on the final wait cycle still counts.
        if (bus.mem_rvalid) begin
          loadDone  = 1'b1;
          stateNext = WB;
        end else if ((waitCnt + 8'd1) == TimeoutVal) begin
          timeout   = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Load context, wait counter and register-file write outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt    <= 8'h00;
      ldRd       <= 5'h00;
      ldRegwrite <= 1'b0;
      ldFunct3   <= 3'h0;
      ldAddr     <= 2'h0;
      regWriteQ  <= 1'b0;
      writeAddrQ <= 5'h00;
      writeDataQ <= 32'h0;
      errQ       <= 1'b0;
    end else begin
      regWriteQ <= 1'b0;
      errQ      <= rejectLoad || timeout;
      if (takeNonLoad) begin
        regWriteQ  <= bus.in_regwrite && (bus.in_rd != 5'd0);
        writeAddrQ <= bus.in_rd;
        writeDataQ <= bus.in_result;
      end
      if (takeLoad) begin
        ldRd       <= bus.in_rd;
        ldRegwrite <= bus.in_regwrite;
        ldFunct3   <= bus.in_funct3;
        ldAddr     <= bus.in_result[1:0];
        waitCnt    <= 8'h00;
      end
      if (state == WAIT_MEM && !bus.mem_rvalid) begin
        waitCnt <= timeout ? 8'h00 : waitCnt + 8'd1;
      end
      if (loadDone) begin
        regWriteQ  <= ldRegwrite && (ldRd != 5'd0);
        writeAddrQ <= ldRd;
        writeDataQ <= loadData;
      end
    end
  end

endmodule
